// File: rtl/core_block_controller.sv
// Core-side block controller: accepts one block assignment from the dispatcher,
// spreads the block's threads across the core's warps, launches the active warps,
// gathers their completions and holds done until the core is reset.
module core_block_controller #(
   parameter int NUM_WARPS        = 4,
   parameter int THREADS_PER_WARP = 8,
   parameter int DATA_WIDTH       = 8
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      block_reset_i,
   input  logic                                      start_i,
   input  logic [DATA_WIDTH-1:0]                     block_id_i,
   input  logic [DATA_WIDTH-1:0]                     threads_per_block_i,
   input  logic [NUM_WARPS-1:0]                      warp_done_i,
   output logic [NUM_WARPS-1:0]                      warp_start_o,
   output logic [NUM_WARPS*THREADS_PER_WARP-1:0]     warp_thread_mask_o,
   output logic [NUM_WARPS-1:0][DATA_WIDTH-1:0]      warp_base_tid_o,
   output logic [DATA_WIDTH-1:0]                     block_id_o,
   output logic                                      busy_o,
   output logic                                      done_o,
   output logic                                      cfg_error_o
);

   localparam int CAPACITY = NUM_WARPS * THREADS_PER_WARP;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [NUM_WARPS-1:0]                  active_mask_q, active_mask_d;
   logic [NUM_WARPS-1:0]                  done_seen_q, done_seen_d;
   logic [NUM_WARPS-1:0]                  warp_start_q, warp_start_d;
   logic [CAPACITY-1:0]                   lane_mask_q, lane_mask_d;
   logic [NUM_WARPS-1:0][DATA_WIDTH-1:0]  base_tid_q, base_tid_d;
   logic [DATA_WIDTH-1:0]                 block_id_q, block_id_d;
   logic                                  busy_q, busy_d;
   logic                                  done_q, done_d;
   logic                                  cfg_error_q, cfg_error_d;

   logic [31:0]                           tpb_wide;
   logic [31:0]                           n_clamped;
   logic                                  clamp;
   logic [DATA_WIDTH-1:0]                 block_base;
   logic [NUM_WARPS-1:0]                  new_active;
   logic [CAPACITY-1:0]                   new_lanes;
   logic [NUM_WARPS-1:0][DATA_WIDTH-1:0]  new_base;

   // Work out the launch image (active warps, lane enables, base ids) from the incoming assignment
   always_comb begin
      tpb_wide   = 32'(threads_per_block_i);
      clamp      = tpb_wide > 32'(CAPACITY);
      n_clamped  = clamp ? 32'(CAPACITY) : tpb_wide;
      block_base = block_id_i * threads_per_block_i;
      new_active = '0;
      new_lanes  = '0;
      new_base   = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         if (32'(w * THREADS_PER_WARP) < n_clamped) begin
            new_active[w] = 1'b1;
            new_base[w]   = block_base + DATA_WIDTH'(w * THREADS_PER_WARP);
         end
         for (int t = 0; t < THREADS_PER_WARP; t++) begin
            new_lanes[w*THREADS_PER_WARP + t] = (32'(w * THREADS_PER_WARP + t) < n_clamped);
         end
      end
   end

   // State register; either reset source returns the controller to IDLE
   always_ff @(posedge clk) begin
      if (reset || block_reset_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a zero-thread block skips RUN, RUN ends once every active warp reported
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = LAUNCH;
         LAUNCH:  state_d = (active_mask_q != '0) ? RUN : DONE;
         RUN:     if ((done_seen_q | (warp_done_i & active_mask_q)) == active_mask_q) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values so every output can be registered alongside the state
   always_comb begin
      warp_start_d  = '0;
      active_mask_d = active_mask_q;
      done_seen_d   = done_seen_q;
      lane_mask_d   = lane_mask_q;
      base_tid_d    = base_tid_q;
      block_id_d    = block_id_q;
      cfg_error_d   = cfg_error_q;
      busy_d        = (state_d == LAUNCH) || (state_d == RUN);
      done_d        = (state_d == DONE);
      case (state_q)
         IDLE: begin
            if (start_i) begin
               active_mask_d = new_active;
               done_seen_d   = '0;
               lane_mask_d   = new_lanes;
               base_tid_d    = new_base;
               block_id_d    = block_id_i;
               cfg_error_d   = cfg_error_q | clamp;
               warp_start_d  = new_active;
            end
         end
         RUN:     done_seen_d = done_seen_q | (warp_done_i & active_mask_q);
         default: ;
      endcase
   end

   // Registered outputs and block bookkeeping, cleared by either reset source
   always_ff @(posedge clk) begin
      if (reset || block_reset_i) begin
         active_mask_q <= '0;
         done_seen_q   <= '0;
         warp_start_q  <= '0;
         lane_mask_q   <= '0;
         base_tid_q    <= '0;
         block_id_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         active_mask_q <= active_mask_d;
         done_seen_q   <= done_seen_d;
         warp_start_q  <= warp_start_d;
         lane_mask_q   <= lane_mask_d;
         base_tid_q    <= base_tid_d;
         block_id_q    <= block_id_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   // Configuration error is sticky across blocks; only the global reset clears it
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_error_q <= 1'b0;
      end else if (!block_reset_i) begin
         cfg_error_q <= cfg_error_d;
      end
   end

   assign warp_start_o       = warp_start_q;
   assign warp_thread_mask_o = lane_mask_q;
   assign warp_base_tid_o    = base_tid_q;
   assign block_id_o         = block_id_q;
   assign busy_o             = busy_q;
   assign done_o             = done_q;
   assign cfg_error_o        = cfg_error_q;

endmodule

// File: tb/tb_core_block_controller.sv
// Self-checking bench for core_block_controller: directed block scenarios plus
// randomized blocks, all checked against an arithmetic model of the block split.
module tb_core_block_controller;

   localparam int NW  = 4;
   localparam int TPW = 8;
   localparam int DW  = 8;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic                  block_reset = 1'b0;
   logic                  start = 1'b0;
   logic [DW-1:0]         block_id = '0;
   logic [DW-1:0]         tpb = '0;
   logic [NW-1:0]         warp_done = '0;
   logic [NW-1:0]         warp_start;
   logic [NW*TPW-1:0]     lane_mask;
   logic [NW-1:0][DW-1:0] base_tid;
   logic [DW-1:0]         block_id_q;
   logic                  busy;
   logic                  done;
   logic                  cfg_error;

   int vectors = 0;
   int miscompares = 0;
   bit exp_cfg = 1'b0;

   core_block_controller #(.NUM_WARPS(NW), .THREADS_PER_WARP(TPW), .DATA_WIDTH(DW)) dut (
      .clk                 (clk),
      .reset               (reset),
      .block_reset_i       (block_reset),
      .start_i             (start),
      .block_id_i          (block_id),
      .threads_per_block_i (tpb),
      .warp_done_i         (warp_done),
      .warp_start_o        (warp_start),
      .warp_thread_mask_o  (lane_mask),
      .warp_base_tid_o     (base_tid),
      .block_id_o          (block_id_q),
      .busy_o              (busy),
      .done_o              (done),
      .cfg_error_o         (cfg_error)
   );

   always #5 clk = ~clk;

   // Reference model: threads actually placed on the core
   function automatic int model_n(input int threads);
      return (threads > NW*TPW) ? NW*TPW : threads;
   endfunction

   // Reference model: warps that receive at least one thread
   function automatic logic [NW-1:0] model_active(input int threads);
      logic [NW-1:0] a;
      a = '0;
      for (int w = 0; w < NW; w++) a[w] = (model_n(threads) > w*TPW);
      return a;
   endfunction

   // Reference model: per-warp lane enables as a count of filled lanes
   function automatic logic [NW*TPW-1:0] model_lanes(input int threads);
      logic [NW*TPW-1:0] l;
      int cnt;
      l = '0;
      for (int w = 0; w < NW; w++) begin
         cnt = model_n(threads) - w*TPW;
         if (cnt < 0) cnt = 0;
         if (cnt > TPW) cnt = TPW;
         l[w*TPW +: TPW] = 8'((1 << cnt) - 1);
      end
      return l;
   endfunction

   // Reference model: global id of lane 0, modulo the data width
   function automatic logic [DW-1:0] model_base(input int bid, input int threads, input int w);
      if (model_n(threads) <= w*TPW) return '0;
      return DW'((bid*threads + w*TPW) % 256);
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int threads, input int bid);
      tpb = DW'(threads);
      block_id = DW'(bid);
      start = 1'b1;
      cycle();
   endtask

   task automatic pulse_block_reset();
      start = 1'b0;
      warp_done = '0;
      block_reset = 1'b1;
      cycle();
      block_reset = 1'b0;
   endtask

   // Full block lifecycle: launch image, completion tracking, hold, then block_reset
   task automatic run_block(input int threads, input int bid, input bit simul, input bit noise);
      logic [NW-1:0] act, remaining, seen, pick;
      int w;
      act = model_active(threads);
      if (threads > NW*TPW) exp_cfg = 1'b1;
      warp_done = '0;
      applyStimulus(threads, bid);
      vectors++;
      if (warp_start !== act) begin
         miscompares++;
         $display("[TB] FAIL launch_warp_start tpb=%0d got=%b want=%b", threads, warp_start, act);
      end
      vectors++;
      if (lane_mask !== model_lanes(threads)) begin
         miscompares++;
         $display("[TB] FAIL launch_mask tpb=%0d got=%h want=%h", threads, lane_mask, model_lanes(threads));
      end
      for (int i = 0; i < NW; i++) begin
         vectors++;
         if (base_tid[i] !== model_base(bid, threads, i)) begin
            miscompares++;
            $display("[TB] FAIL base_tid[%0d] bid=%0d tpb=%0d got=%0d want=%0d", i, bid, threads, base_tid[i], model_base(bid, threads, i));
         end
      end
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || block_id_q !== DW'(bid) || cfg_error !== exp_cfg) begin
         miscompares++;
         $display("[TB] FAIL launch_status got busy=%b done=%b bid=%0d cfg=%b want 1 0 %0d %b", busy, done, block_id_q, cfg_error, bid, exp_cfg);
      end
      if (noise) warp_done = '1;
      cycle();
      warp_done = '0;
      vectors++;
      if (warp_start !== '0 || busy !== (act != '0) || done !== (act == '0)) begin
         miscompares++;
         $display("[TB] FAIL post_launch got ws=%b busy=%b done=%b want 0 %b %b", warp_start, busy, done, act != '0, act == '0);
      end
      remaining = act;
      seen = '0;
      while (remaining != '0) begin
         if (simul) begin
            pick = remaining;
         end else begin
            do w = $urandom_range(0, NW-1); while (!remaining[w]);
            pick = '0;
            pick[w] = 1'b1;
         end
         warp_done = pick;
         if (noise) warp_done = warp_done | (NW'($urandom) & (~act | seen));
         remaining = remaining & ~pick;
         seen = seen | pick;
         cycle();
         if (!noise) warp_done = '0;
         vectors++;
         if (done !== (remaining == '0) || busy !== (remaining != '0)) begin
            miscompares++;
            $display("[TB] FAIL run_progress remaining=%b got done=%b busy=%b", remaining, done, busy);
         end
         if ($urandom_range(0, 1) == 1 && remaining != '0) begin
            warp_done = '0;
            cycle();
         end
      end
      start = 1'b0;
      cycle();
      cycle();
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || lane_mask !== model_lanes(threads) || base_tid[NW-1] !== model_base(bid, threads, NW-1)) begin
         miscompares++;
         $display("[TB] FAIL done_hold got done=%b busy=%b mask=%h", done, busy, lane_mask);
      end
      pulse_block_reset();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || lane_mask !== '0 || block_id_q !== '0 || base_tid !== '0 || cfg_error !== exp_cfg) begin
         miscompares++;
         $display("[TB] FAIL block_reset got done=%b busy=%b mask=%h bid=%0d cfg=%b want cfg=%b", done, busy, lane_mask, block_id_q, cfg_error, exp_cfg);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      exp_cfg = 1'b0;
      vectors++;
      if (warp_start !== '0 || lane_mask !== '0 || base_tid !== '0 || block_id_q !== '0 || busy !== 1'b0 || done !== 1'b0 || cfg_error !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_state got ws=%b mask=%h busy=%b done=%b cfg=%b want all zero", warp_start, lane_mask, busy, done, cfg_error);
      end
   endtask

   task automatic test_full_block();
      run_block(32, 3, 1'b0, 1'b0);
   endtask

   task automatic test_partial_block();
      run_block(13, 9, 1'b0, 1'b1);
   endtask

   task automatic test_zero_threads();
      run_block(0, 5, 1'b0, 1'b1);
   endtask

   task automatic test_clamp();
      run_block(40, 2, 1'b0, 1'b0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      exp_cfg = 1'b0;
      vectors++;
      if (cfg_error !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL cfg_error_reset got=%b want=0", cfg_error);
      end
   endtask

   task automatic test_simultaneous();
      run_block(32, 1, 1'b1, 1'b1);
   endtask

   task automatic test_abort_restart();
      applyStimulus(32, 5);
      cycle();
      warp_done = 4'b0011;
      cycle();
      warp_done = 4'b0100;
      cycle();
      warp_done = '0;
      pulse_block_reset();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || warp_start !== '0) begin
         miscompares++;
         $display("[TB] FAIL abort got done=%b busy=%b ws=%b want 0 0 0", done, busy, warp_start);
      end
      cycle();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_idle got done=%b busy=%b want 0 0", done, busy);
      end
      run_block(32, 7, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 24; k++) begin
         run_block($urandom_range(0, 40), $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_full_block();
      test_partial_block();
      test_zero_threads();
      test_clamp();
      test_simultaneous();
      test_abort_restart();
      test_random();
      test_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
